// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, types and byte/word helpers
// Purpose: S-box and round-constant tables, the 16-byte state type, the FSM
//          encoding, and the GF(2^8)/word helpers used by sub_bytes and aes_key_step.
// Ports:   none (package).
package aes_pkg;

  // State layout is row-major: element 4*r+c holds row r, column c.
  typedef logic [7:0] state_t [16];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Entry i is the constant for round i+1.
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Words are packed {row0, row1, row2, row3}; row 0 is the leading byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one combinational AES-128 key-expansion step
// Purpose: derive round key i from round key i-1 and rcon[i].
// Ports:   rk_i   in  16x8  current round key, row-major (column c = word c)
//          rcon_i in  8     round constant for the key being produced
//          rk_o   out 16x8  next round key, same layout
module aes_key_step
  import aes_pkg::*;
(
  input  logic [7:0] rk_i [16],
  input  logic [7:0] rcon_i,
  output logic [7:0] rk_o [16]
);

  logic [31:0] w_cur [4];
  logic [31:0] w_nxt [4];
  logic [31:0] t_word;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_cur[c] = {rk_i[c], rk_i[4+c], rk_i[8+c], rk_i[12+c]};
    end

    t_word = sub_word(rot_word(w_cur[3])) ^ {rcon_i, 24'h000000};

    // Each new word chains off the one just produced.
    w_nxt[0] = w_cur[0] ^ t_word;
    w_nxt[1] = w_cur[1] ^ w_nxt[0];
    w_nxt[2] = w_cur[2] ^ w_nxt[1];
    w_nxt[3] = w_cur[3] ^ w_nxt[2];

    for (int c = 0; c < 4; c++) begin
      rk_o[c]    = w_nxt[c][31:24];
      rk_o[4+c]  = w_nxt[c][23:16];
      rk_o[8+c]  = w_nxt[c][15:8];
      rk_o[12+c] = w_nxt[c][7:0];
    end
  end

endmodule

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - iterative AES-128 encryption core, one round per clock
// Purpose: takes the state already XORed with round key 0 plus the cipher key,
//          runs rounds 1..NR with on-the-fly key expansion, presents ciphertext.
// Ports:   clk          in  1     rising-edge clock
//          rst          in  1     synchronous active-high reset
//          data         in  16x8  start state, row-major (4*r+c)
//          key          in  16x8  cipher key (round key 0), row-major
//          read_enable  in  1     level start request; also holds the result in DONE
//          out_data     out 16x8  ciphertext, row-major
//          done         out 1     high while out_data holds a valid result
module sub_bytes
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data [16],
  input  logic [7:0] key [16],
  input  logic       read_enable,
  output logic [7:0] out_data [16],
  output logic       done
);

  fsm_e       state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [7:0] st_q  [16];
  logic [7:0] st_d  [16];
  logic [7:0] rk_q  [16];
  logic [7:0] rk_d  [16];
  logic [7:0] out_q [16];
  logic [7:0] out_d [16];
  logic       done_q, done_d;

  logic [7:0] sb      [16];
  logic [7:0] sr      [16];
  logic [7:0] mc      [16];
  logic [7:0] st_next [16];
  logic [7:0] rk_next [16];
  logic [7:0] rcon;
  logic       last_round;

  assign last_round = (rnd_q == 4'(NR));

  // rnd_q is 0 outside RUN; the guard keeps the table index in range there.
  assign rcon = (rnd_q >= 4'd1 && rnd_q <= 4'd10) ? RCON[rnd_q - 4'd1] : 8'h00;

  aes_key_step u_key_step (
    .rk_i   (rk_q),
    .rcon_i (rcon),
    .rk_o   (rk_next)
  );

  // Round datapath: SubBytes -> ShiftRows -> MixColumns (bypassed in the last round) -> AddRoundKey.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = SBOX[st_q[i]];
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[4*r+c] = sb[4*r + ((c + r) % 4)];
      end
    end
    // 3*a is written as xtime(a) ^ a.
    for (int c = 0; c < 4; c++) begin
      mc[c]    = xtime(sr[c]) ^ xtime(sr[4+c]) ^ sr[4+c] ^ sr[8+c] ^ sr[12+c];
      mc[4+c]  = sr[c] ^ xtime(sr[4+c]) ^ xtime(sr[8+c]) ^ sr[8+c] ^ sr[12+c];
      mc[8+c]  = sr[c] ^ sr[4+c] ^ xtime(sr[8+c]) ^ xtime(sr[12+c]) ^ sr[12+c];
      mc[12+c] = xtime(sr[c]) ^ sr[c] ^ sr[4+c] ^ sr[8+c] ^ xtime(sr[12+c]);
    end
    for (int i = 0; i < 16; i++) begin
      st_next[i] = (last_round ? sr[i] : mc[i]) ^ rk_next[i];
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    rk_d    = rk_q;
    out_d   = out_q;
    done_d  = done_q;

    unique case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (read_enable) begin
          st_d    = data;
          rk_d    = key;
          rnd_d   = 4'd1;
          state_d = ST_RUN;
        end
      end
      // read_enable is deliberately not looked at here.
      ST_RUN: begin
        st_d = st_next;
        rk_d = rk_next;
        if (last_round) begin
          out_d   = st_next;
          done_d  = 1'b1;
          rnd_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      // Leaving DONE needs read_enable low, so a held request cannot restart.
      ST_DONE: begin
        if (!read_enable) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        done_d  = 1'b0;
        rnd_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '{default: 8'h00};
      rk_q    <= '{default: 8'h00};
      out_q   <= '{default: 8'h00};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out_data = out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sub_bytes.sv
// tb/tb_sub_bytes.sv - self-checking bench for the sub_bytes AES-128 core
module tb_sub_bytes;

  localparam logic [127:0] FIPS_IN  = 128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08;
  localparam logic [127:0] FIPS_KEY = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
  localparam logic [127:0] FIPS_CT  = 128'h3902dc19_25dc116a_8409850b_1dfb9732;
  localparam logic [127:0] R1_ST    = 128'ha4686b02_9c9f5b6a_7f35ea50_f22b4349;
  localparam logic [127:0] R1_RK    = 128'ha088232a_fa54a36c_fe2c3976_17b13905;

  logic       clk;
  logic       rst;
  logic       read_enable;
  logic [7:0] data     [16];
  logic [7:0] key      [16];
  logic [7:0] out_data [16];
  logic       done;

  logic [127:0] data_flat, key_flat, out_flat, st_probe, rk_probe;

  logic [7:0] sb_m [256];

  int n_cmp = 0;
  int n_bad = 0;

  sub_bytes dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .key         (key),
    .read_enable (read_enable),
    .out_data    (out_data),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte i of a flat vector sits at [127-8*i -: 8], i = 4*row + col.
  always_comb begin
    out_flat = '0;
    st_probe = '0;
    rk_probe = '0;
    for (int i = 0; i < 16; i++) begin
      data[i] = data_flat[127-8*i -: 8];
      key[i]  = key_flat[127-8*i -: 8];
      out_flat[127-8*i -: 8] = out_data[i];
      st_probe[127-8*i -: 8] = dut.st_q[i];
      rk_probe[127-8*i -: 8] = dut.rk_q[i];
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_cipher(input logic [127:0] din, input logic [127:0] k);
    logic [7:0]  s [4][4];
    logic [7:0]  t [4][4];
    logic [7:0]  coef [4];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  acc;
    logic [127:0] res;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int c = 0; c < 4; c++) begin
      w[c] = {k[127-8*c -: 8], k[127-8*(4+c) -: 8], k[127-8*(8+c) -: 8], k[127-8*(12+c) -: 8]};
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_m[tmp[31:24]], sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = din[127-8*(4*r+c) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb_m[s[r][(c + r) % 4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < 10) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], t[j][c]);
          end else begin
            acc = t[r][c];
          end
          s[r][c] = acc ^ w[4*rnd + c][31-8*r -: 8];
        end
    end
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(4*r+c) -: 8] = s[r][c];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until done is seen; n = -1 if the budget runs out.
  task automatic wait_done(input int budget, output int n, output logic changed);
    logic [127:0] start_out;
    start_out = out_flat;
    changed = 1'b0;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        break;
      end
      if (out_flat !== start_out) changed = 1'b1;
    end
  endtask

  initial begin
    logic [7:0]   inv_b, aff_b;
    logic [127:0] din, kin;
    logic         seen, chg;
    int           n;

    for (int a = 0; a < 256; a++) begin
      inv_b = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv_b = 8'(x);
      aff_b = inv_b;
      sb_m[a] = aff_b ^ {aff_b[6:0], aff_b[7]} ^ {aff_b[5:0], aff_b[7:6]}
              ^ {aff_b[4:0], aff_b[7:5]} ^ {aff_b[3:0], aff_b[7:4]} ^ 8'h63;
    end

    rst = 1'b1;
    read_enable = 1'b0;
    data_flat = '0;
    key_flat = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_out", out_flat, 128'd0);
    chk("reset_state_reg", st_probe, 128'd0);
    rst = 1'b0;

    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || out_flat !== 128'd0) seen = 1'b1;
    end
    chk("idle_no_start", 128'(seen), 128'd0);

    data_flat = FIPS_IN;
    key_flat = FIPS_KEY;
    read_enable = 1'b1;
    @(negedge clk);
    chk("run_done_low", 128'(done), 128'd0);
    @(negedge clk);
    chk("round1_state", st_probe, R1_ST);
    chk("round1_key", rk_probe, R1_RK);
    wait_done(20, n, chg);
    chk("fips_latency", 128'(n), 128'd9);
    chk("fips_out_frozen_in_run", 128'(chg), 128'd0);
    chk("fips_ct", out_flat, FIPS_CT);

    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done !== 1'b1) seen = 1'b1;
    end
    chk("hold_done", 128'(seen), 128'd0);
    chk("hold_out", out_flat, FIPS_CT);
    read_enable = 1'b0;
    @(negedge clk);
    chk("drop_done", 128'(done), 128'd0);
    chk("drop_keeps_out", out_flat, FIPS_CT);

    din = {$urandom, $urandom, $urandom, $urandom};
    kin = {$urandom, $urandom, $urandom, $urandom};
    data_flat = din;
    key_flat = kin;
    read_enable = 1'b1;
    wait_done(20, n, chg);
    chk("rerun_latency", 128'(n), 128'd11);
    chk("rerun_out_frozen", 128'(chg), 128'd0);
    chk("rerun_ct", out_flat, ref_cipher(din, kin));

    read_enable = 1'b0;
    @(negedge clk);
    data_flat = FIPS_IN;
    key_flat = FIPS_KEY;
    read_enable = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    read_enable = 1'b0;
    @(negedge clk);
    chk("midrun_reset_done", 128'(done), 128'd0);
    chk("midrun_reset_out", out_flat, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 128'(done), 128'd0);
    read_enable = 1'b1;
    wait_done(20, n, chg);
    chk("restart_latency", 128'(n), 128'd11);
    chk("restart_ct", out_flat, FIPS_CT);

    read_enable = 1'b0;
    @(negedge clk);
    data_flat = FIPS_IN;
    key_flat = FIPS_KEY;
    read_enable = 1'b1;
    @(negedge clk);
    data_flat = {$urandom, $urandom, $urandom, $urandom};
    key_flat = {$urandom, $urandom, $urandom, $urandom};
    read_enable = 1'b0;
    wait_done(20, n, chg);
    chk("input_change_latency", 128'(n), 128'd10);
    chk("input_change_ct", out_flat, FIPS_CT);
    @(negedge clk);
    chk("auto_drop_done", 128'(done), 128'd0);

    for (int t = 0; t < 6; t++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      kin = {$urandom, $urandom, $urandom, $urandom};
      data_flat = din;
      key_flat = kin;
      read_enable = 1'b1;
      wait_done(20, n, chg);
      chk($sformatf("rand%0d_latency", t), 128'(n), 128'd11);
      chk($sformatf("rand%0d_ct", t), out_flat, ref_cipher(din, kin));
      read_enable = 1'b0;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
